id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
ID/EX pipeline register of the 5-stage MIPS core. It sits directly downstream of the hazard detection unit. It captures decoded operands and control from ID each cycle. When the hazard unit deasserts Valid (load-use hazard), it inserts a bubble. It supplies ID_EX_M and the destination address back to the hazard unit, and keeps saturating bubble and flush counters for debug.

Parameters:
BUBBLE_M, 3'b111, M-control value loaded on bubble, flush and reset; must never equal 3'b000, the load encoding matched by the hazard unit
CNT_W, 16, width of the bubble and flush counters

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  asynchronous reset, active-high
start_i  input  1  pipeline enable; 0 = hold all state
valid_i  input  1  from hazard unit Valid; 0 = insert bubble this cycle
flush_i  input  1  branch/jump taken; discard the ID instruction
pc_i  input  32  PC+4 of the ID instruction
rs_data_i, rt_data_i  input  32 each  register file read data
imm_i  input  32  sign-extended immediate
rs_addr_i, rt_addr_i, rd_addr_i  input  5 each  register specifiers
wb_i  input  2  WB control {RegWrite, MemtoReg}
m_i  input  3  M control (3'b000 = load)
ex_i  input  4  EX control {RegDst, ALUSrc, ALUOp[1:0]}
pc_o, rs_data_o, rt_data_o, imm_o  output  32 each  registered copies
rs_addr_o, rt_addr_o, rd_addr_o  output  5 each  registered; rt_addr_o drives the hazard unit regd_addr
wb_o  output  2  registered WB control
m_o  output  3  registered M control; drives the hazard unit ID_EX_M
ex_o  output  4  registered EX control
valid_o  output  1  1 = real instruction in EX
bubble_cnt_o  output  CNT_W  bubbles inserted, saturating
flush_cnt_o  output  CNT_W  flushes taken, saturating

Behaviour:
- Reset (rst_i=1, asynchronous, immediate): all outputs 0, except m_o = BUBBLE_M. This holds while rst_i is high and also applies mid-operation; counters clear.
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N. No combinational input-to-output path.
- Per-edge priority, highest first:
  1. start_i=0: hold every register, including counters.
  2. flush_i=1: load a NOP. flush_cnt_o+1. bubble_cnt_o unchanged, even if valid_i=0 in the same cycle.
  3. valid_i=0: load a NOP. bubble_cnt_o+1.
  4. Otherwise: load all inputs; valid_o=1.
- NOP: wb_o=0, m_o=BUBBLE_M, ex_o=0, all addresses 0, all data fields 0, valid_o=0.
- Because a bubble's m_o is never 3'b000, the hazard unit cannot re-detect a hazard against a bubble. A load-use stall therefore lasts exactly one cycle.
- Counters saturate at all-ones and never wrap. Both increment only when start_i=1.
- Back-to-back bubbles are legal; each valid_i=0 cycle adds one.
- X on data inputs during NOP cycles must not propagate; outputs stay 0.

Test Plan:
- Reset: assert rst_i mid-clock with arbitrary inputs -> all outputs 0 immediately, m_o=3'b111, counters 0; remain so until an edge after rst_i falls.
- Pass-through: start_i=1, valid_i=1, pc_i=32'h0000_0010, rt_addr_i=5'd8, m_i=3'b000, wb_i=2'b11 -> next cycle pc_o=32'h10, rt_addr_o=8, m_o=3'b000, wb_o=2'b11, valid_o=1.
- Load-use: lw $8 then add $9,$8,$8 with hazard unit connected -> exactly one bubble (m_o=3'b111, wb_o=0, valid_o=0); the add enters EX the following cycle; bubble_cnt_o=1.
- Flush with bubble: flush_i=1 and valid_i=0 on the same edge -> NOP loaded, flush_cnt_o=1, bubble_cnt_o unchanged.
- Hold: start_i=0 for 3 cycles with changing inputs and valid_i=0 -> all outputs and counters constant.
- Saturation: CNT_W=4, 20 consecutive valid_i=0 cycles -> bubble_cnt_o stops at 4'hF.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded operands and control from ID each
// cycle, inserts NOP bubbles on load-use stalls or flushes, and counts both events.
module id_ex_reg #(
  parameter logic [2:0] BUBBLE_M = 3'b111,
  parameter int         CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      rs_data_i,
  input  logic [31:0]      rt_data_i,
  input  logic [31:0]      imm_i,
  input  logic [4:0]       rs_addr_i,
  input  logic [4:0]       rt_addr_i,
  input  logic [4:0]       rd_addr_i,
  input  logic [1:0]       wb_i,
  input  logic [2:0]       m_i,
  input  logic [3:0]       ex_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      rs_data_o,
  output logic [31:0]      rt_data_o,
  output logic [31:0]      imm_o,
  output logic [4:0]       rs_addr_o,
  output logic [4:0]       rt_addr_o,
  output logic [4:0]       rd_addr_o,
  output logic [1:0]       wb_o,
  output logic [2:0]       m_o,
  output logic [3:0]       ex_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A NOP is any cycle where the ID instruction must not reach EX.
  logic load_nop;
  assign load_nop = flush_i || !valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_o         <= '0;
      rs_data_o    <= '0;
      rt_data_o    <= '0;
      imm_o        <= '0;
      rs_addr_o    <= '0;
      rt_addr_o    <= '0;
      rd_addr_o    <= '0;
      wb_o         <= '0;
      m_o          <= BUBBLE_M;
      ex_o         <= '0;
      valid_o      <= 1'b0;
      bubble_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else if (start_i) begin
      if (load_nop) begin
        // Constants only, so X on the ID data path never leaks into a bubble.
        pc_o      <= '0;
        rs_data_o <= '0;
        rt_data_o <= '0;
        imm_o     <= '0;
        rs_addr_o <= '0;
        rt_addr_o <= '0;
        rd_addr_o <= '0;
        wb_o      <= '0;
        m_o       <= BUBBLE_M;
        ex_o      <= '0;
        valid_o   <= 1'b0;
        // Flush wins over bubble: a flushed cycle is not also counted as a bubble.
        if (flush_i) begin
          if (flush_cnt_o != CNT_MAX) flush_cnt_o <= flush_cnt_o + CNT_ONE;
        end else begin
          if (bubble_cnt_o != CNT_MAX) bubble_cnt_o <= bubble_cnt_o + CNT_ONE;
        end
      end else begin
        pc_o      <= pc_i;
        rs_data_o <= rs_data_i;
        rt_data_o <= rt_data_i;
        imm_o     <= imm_i;
        rs_addr_o <= rs_addr_i;
        rt_addr_o <= rt_addr_i;
        rd_addr_o <= rd_addr_i;
        wb_o      <= wb_i;
        m_o       <= m_i;
        ex_o      <= ex_i;
        valid_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, pass-through, load-use with a hazard
// unit model, flush/bubble priority, hold, X isolation and counter saturation.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        valid_drv;
  logic        use_hz;
  logic        flush_i;
  logic [31:0] pc_i, rs_data_i, rt_data_i, imm_i;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
  logic [1:0]  wb_i;
  logic [2:0]  m_i;
  logic [3:0]  ex_i;
  logic        valid_i;
  logic        hz_stall;

  logic [31:0] pc_o, rs_data_o, rt_data_o, imm_o;
  logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
  logic [1:0]  wb_o;
  logic [2:0]  m_o;
  logic [3:0]  ex_o;
  logic        valid_o;
  logic [15:0] bubble_cnt_o, flush_cnt_o;

  logic [31:0] s_pc_o, s_rs_data_o, s_rt_data_o, s_imm_o;
  logic [4:0]  s_rs_addr_o, s_rt_addr_o, s_rd_addr_o;
  logic [1:0]  s_wb_o;
  logic [2:0]  s_m_o;
  logic [3:0]  s_ex_o;
  logic        s_valid_o;
  logic [3:0]  s_bubble_cnt_o, s_flush_cnt_o;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Hazard unit model: load in EX whose destination feeds the ID instruction.
  assign hz_stall = use_hz && (m_o == 3'b000) && (rt_addr_o != 5'd0) &&
                    ((rt_addr_o == rs_addr_i) || (rt_addr_o == rt_addr_i));
  assign valid_i  = use_hz ? !hz_stall : valid_drv;

  id_ex_reg dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .valid_i(valid_i), .flush_i(flush_i),
    .pc_i(pc_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
    .wb_i(wb_i), .m_i(m_i), .ex_i(ex_i),
    .pc_o(pc_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
    .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o),
    .wb_o(wb_o), .m_o(m_o), .ex_o(ex_o), .valid_o(valid_o),
    .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  id_ex_reg #(.CNT_W(4)) u_sat (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .valid_i(valid_i), .flush_i(flush_i),
    .pc_i(pc_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
    .wb_i(wb_i), .m_i(m_i), .ex_i(ex_i),
    .pc_o(s_pc_o), .rs_data_o(s_rs_data_o), .rt_data_o(s_rt_data_o), .imm_o(s_imm_o),
    .rs_addr_o(s_rs_addr_o), .rt_addr_o(s_rt_addr_o), .rd_addr_o(s_rd_addr_o),
    .wb_o(s_wb_o), .m_o(s_m_o), .ex_o(s_ex_o), .valid_o(s_valid_o),
    .bubble_cnt_o(s_bubble_cnt_o), .flush_cnt_o(s_flush_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [31:0] imm, input logic [4:0] rsa, input logic [4:0] rta,
                       input logic [4:0] rda, input logic [1:0] wb, input logic [2:0] m,
                       input logic [3:0] ex);
    pc_i = pc; rs_data_i = rsd; rt_data_i = rtd; imm_i = imm;
    rs_addr_i = rsa; rt_addr_i = rta; rd_addr_i = rda;
    wb_i = wb; m_i = m; ex_i = ex;
  endtask

  task automatic check_nop(input string tag);
    check({tag, ".pc"}, pc_o, 32'h0);
    check({tag, ".rs_data"}, rs_data_o, 32'h0);
    check({tag, ".imm"}, imm_o, 32'h0);
    check({tag, ".rt_addr"}, {27'd0, rt_addr_o}, 32'd0);
    check({tag, ".wb"}, {30'd0, wb_o}, 32'd0);
    check({tag, ".m"}, {29'd0, m_o}, 32'd7);
    check({tag, ".ex"}, {28'd0, ex_o}, 32'd0);
    check({tag, ".valid"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; valid_drv = 1'b1; use_hz = 1'b0; flush_i = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 2'd0, 3'd0, 4'd0);

    // Reset state
    step(); step();
    check_nop("rst");
    check("rst.bubble_cnt", {16'd0, bubble_cnt_o}, 32'd0);
    check("rst.flush_cnt", {16'd0, flush_cnt_o}, 32'd0);
    #3 rst_i = 1'b0;

    // Pass-through
    start_i = 1'b1; valid_drv = 1'b1;
    drive(32'h0000_0010, 32'hAAAA_0001, 32'hBBBB_0002, 32'hFFFF_FFFC, 5'd3, 5'd8, 5'd12,
          2'b11, 3'b000, 4'b0110);
    step();
    check("pass.pc", pc_o, 32'h10);
    check("pass.rs_data", rs_data_o, 32'hAAAA_0001);
    check("pass.rt_data", rt_data_o, 32'hBBBB_0002);
    check("pass.imm", imm_o, 32'hFFFF_FFFC);
    check("pass.rt_addr", {27'd0, rt_addr_o}, 32'd8);
    check("pass.rd_addr", {27'd0, rd_addr_o}, 32'd12);
    check("pass.m", {29'd0, m_o}, 32'd0);
    check("pass.wb", {30'd0, wb_o}, 32'd3);
    check("pass.ex", {28'd0, ex_o}, 32'd6);
    check("pass.valid", {31'd0, valid_o}, 32'd1);

    // Asynchronous reset mid-cycle with arbitrary inputs
    drive(32'hDEAD_BEEF, 32'h1234_5678, 32'h8765_4321, 32'h0000_00FF, 5'd9, 5'd10, 5'd11,
          2'b10, 3'b001, 4'b1001);
    #3 rst_i = 1'b1;
    #1 check_nop("arst.now");
    step();
    check_nop("arst.edge");
    #3 rst_i = 1'b0;
    #1 check_nop("arst.release");
    check("arst.bubble_cnt", {16'd0, bubble_cnt_o}, 32'd0);
    step();

    // Load-use: lw $8 then add $9,$8,$8 with hazard unit in the loop
    use_hz = 1'b1;
    drive(32'h0000_0020, 32'h0000_1000, 32'h0, 32'h0000_0004, 5'd1, 5'd8, 5'd0,
          2'b11, 3'b000, 4'b0100);
    step();
    check("lw.m", {29'd0, m_o}, 32'd0);
    check("lw.rt_addr", {27'd0, rt_addr_o}, 32'd8);
    check("lw.valid", {31'd0, valid_o}, 32'd1);
    drive(32'h0000_0024, 32'h0000_0005, 32'h0000_0005, 32'h0, 5'd8, 5'd8, 5'd9,
          2'b10, 3'b010, 4'b1010);
    step();
    check_nop("bubble");
    check("bubble.bubble_cnt", {16'd0, bubble_cnt_o}, 32'd1);
    step();
    check("add.pc", pc_o, 32'h24);
    check("add.rd_addr", {27'd0, rd_addr_o}, 32'd9);
    check("add.m", {29'd0, m_o}, 32'd2);
    check("add.ex", {28'd0, ex_o}, 32'd10);
    check("add.valid", {31'd0, valid_o}, 32'd1);
    check("add.bubble_cnt", {16'd0, bubble_cnt_o}, 32'd1);
    use_hz = 1'b0;

    // Flush and bubble together; X on data inputs
    flush_i = 1'b1; valid_drv = 1'b0;
    drive('x, 'x, 'x, 'x, 'x, 'x, 'x, 'x, 'x, 'x);
    step();
    check_nop("flush");
    check("flush.flush_cnt", {16'd0, flush_cnt_o}, 32'd1);
    check("flush.bubble_cnt", {16'd0, bubble_cnt_o}, 32'd1);

    // Plain bubble with X data
    flush_i = 1'b0;
    step();
    check_nop("xbub");
    check("xbub.rt_data", rt_data_o, 32'h0);
    check("xbub.bubble_cnt", {16'd0, bubble_cnt_o}, 32'd2);
    check("xbub.flush_cnt", {16'd0, flush_cnt_o}, 32'd1);

    // Hold: load a real instruction, then start_i=0 for 3 cycles
    valid_drv = 1'b1;
    drive(32'h0000_0100, 32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 5'd4, 5'd5, 5'd6,
          2'b01, 3'b100, 4'b0011);
    step();
    check("hold.load_pc", pc_o, 32'h100);
    start_i = 1'b0; valid_drv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flush_i = i[0];
      drive(32'h0000_0200 + i, 32'($urandom), 32'($urandom), 32'($urandom), 5'(i + 20),
            5'(i + 21), 5'(i + 22), 2'(i), 3'b000, 4'(i));
      step();
      check("hold.pc", pc_o, 32'h100);
      check("hold.rt_data", rt_data_o, 32'h22);
      check("hold.rd_addr", {27'd0, rd_addr_o}, 32'd6);
      check("hold.m", {29'd0, m_o}, 32'd4);
      check("hold.valid", {31'd0, valid_o}, 32'd1);
      check("hold.bubble_cnt", {16'd0, bubble_cnt_o}, 32'd2);
      check("hold.flush_cnt", {16'd0, flush_cnt_o}, 32'd1);
    end
    flush_i = 1'b0;

    // Saturation: 20 bubbles into the 4-bit counter instance
    #3 rst_i = 1'b1;
    #1 rst_i = 1'b0;
    check("sat.reset", {28'd0, s_bubble_cnt_o}, 32'd0);
    start_i = 1'b1; valid_drv = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) check("sat.cnt14", {28'd0, s_bubble_cnt_o}, 32'd14);
      if (i == 15) check("sat.cnt15", {28'd0, s_bubble_cnt_o}, 32'd15);
    end
    check("sat.cnt20", {28'd0, s_bubble_cnt_o}, 32'd15);
    check("sat.flush_cnt", {28'd0, s_flush_cnt_o}, 32'd0);
    check("sat.wide_cnt", {16'd0, bubble_cnt_o}, 32'd20);
    check("sat.m", {29'd0, s_m_o}, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
